// File: rtl/add_req_pkg.sv
// Shared types and defaults for the start/valid adder requester.
package add_req_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int W_DEF       = 12;
    localparam int TIMEOUT_DEF = 4;
    localparam int CNT_W_DEF   = 16;
    localparam int TMR_W_DEF   = $clog2(TIMEOUT_DEF + 1);

    function automatic int tmr_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/add_req_timer.sv
// WAIT-phase timeout counter: clear loads TIMEOUT-1, enable counts down, expire when zero.
// Expire is combinational from the count, so the final WAIT cycle is the TIMEOUT-th one.
module add_req_timer
    import add_req_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int TW = tmr_width(TIMEOUT);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = TW'(TIMEOUT - 1);
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/add_req_initiator.sv
// Single-outstanding requester: accept operands, pulse start, await valid (or timeout), present result.
// Result appears 2 edges after accept with a 1-cycle responder; held until out_ready, no accept meanwhile.
module add_req_initiator
    import add_req_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             start,
    output logic [W-1:0]     a,
    output logic [W-1:0]     b,
    input  logic [W-1:0]     y,
    input  logic             valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_err,
    output logic             err_unexp,
    output logic [CNT_W-1:0] txn_cnt
);

    state_e           state_q, state_d;
    logic             start_q, start_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_sum_q, out_sum_d;
    logic             out_err_q, out_err_d;
    logic             err_unexp_q, err_unexp_d;
    logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
    logic             tmr_clr, tmr_en, tmr_expire;

    add_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        start_d     = 1'b0;
        a_d         = a_q;
        b_d         = b_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_err_d   = out_err_q;
        txn_cnt_d   = txn_cnt_q;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        // A responder valid is only legitimate while a request is awaiting its answer.
        err_unexp_d = err_unexp_q | (valid && state_q != WAIT);

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tmr_clr = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // Valid takes priority over an expiry in the same cycle.
                if (valid) begin
                    out_sum_d   = y;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else if (tmr_expire) begin
                    out_sum_d   = '0;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    txn_cnt_d   = txn_cnt_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_err_q   <= 1'b0;
            err_unexp_q <= 1'b0;
            txn_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_err_q   <= out_err_d;
            err_unexp_q <= err_unexp_d;
            txn_cnt_q   <= txn_cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign start     = start_q;
    assign a         = a_q;
    assign b         = b_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_err   = out_err_q;
    assign err_unexp = err_unexp_q;
    assign txn_cnt   = txn_cnt_q;

endmodule
